// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 arithmetic path: default width and the
// bit-serial subtractor FSM encoding.
package alu4_pkg;

  localparam int unsigned ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    SUB_IDLE  = 2'd0,
    SUB_SHIFT = 2'd1,
    SUB_DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/sub_serial_sub1.sv
// Gate cells and the combinational 1-bit full subtractor sub1 built from them.
module xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module sub1 (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic out,
  output logic borrow_out
);

  logic ab_x;
  logic gen_b;
  logic prop_b;

  xor2 u_x0 (.a(a),     .b(b),         .y(ab_x));
  xor2 u_x1 (.a(ab_x),  .b(borrow_in), .y(out));

  // Borrow generated when a=0,b=1; propagated when a==b.
  and2 u_a0 (.a(~a),    .b(b),         .y(gen_b));
  and2 u_a1 (.a(~ab_x), .b(borrow_in), .y(prop_b));
  or2  u_o0 (.a(gen_b), .b(prop_b),    .y(borrow_out));

endmodule

// File: rtl/sub_serial.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, LSB first.
// Optional overflow/zero flags are built when SUB_SERIAL_FLAGS_EN is defined.
module sub_serial
  import alu4_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  sub_state_t       state;
  sub_state_t       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             shift_en;
  logic             last_bit;
  logic             bit_d;
  logic             bit_br;

  sub1 u_sub1 (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .borrow_in (br),
    .out       (bit_d),
    .borrow_out(bit_br)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= SUB_IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    last_bit   = 1'b0;
    case (state)
      SUB_IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          state_next = SUB_SHIFT;
        end
      end
      SUB_SHIFT: begin
        shift_en = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_bit   = 1'b1;
          state_next = SUB_DONE;
        end
      end
      SUB_DONE: begin
        if (out_valid && out_ready) state_next = SUB_IDLE;
      end
      default: state_next = SUB_IDLE;
    endcase
  end

  // Operand/result shift registers, borrow chain and handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      borrow_out <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
    end else begin
      in_ready  <= (state_next == SUB_IDLE);
      out_valid <= (state_next == SUB_DONE);
      if (accept) begin
        a_sr <= a;
        b_sr <= b;
        br   <= borrow_in;
        cnt  <= '0;
      end else if (shift_en) begin
        res  <= {bit_d, res[WIDTH-1:1]};
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        br   <= bit_br;
        cnt  <= cnt + CNT_W'(1);
        if (last_bit) borrow_out <= bit_br;
      end
    end
  end

  assign diff = res;

`ifdef SUB_SERIAL_FLAGS_EN
  logic ovf_q;
  logic zero_q;

  // Flags settle on the final shift edge, together with the last result bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q  <= br ^ bit_br;
      zero_q <= ({bit_d, res[WIDTH-1:1]} == '0);
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule
